// File: rtl/elevator_pkg.sv
// Shared types and call-detection helpers for the elevator dispatcher.
// Helpers take calls widened to MAX_FLOORS so one definition serves every floor count.
package elevator_pkg;

  localparam int NUM_FLOORS_DEF = 4;
  localparam int MAX_FLOORS     = 16;
  localparam int MAX_FW         = 4;

  typedef enum logic [2:0] {
    IDLE,
    STEP_UP,
    STEP_DOWN,
    WAIT_MOVE,
    DOOR_OPEN
  } disp_state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  function automatic logic call_above(input logic [MAX_FLOORS-1:0] calls,
                                      input logic [MAX_FW-1:0]     pos);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (calls[i] && (i > int'(pos))) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic call_below(input logic [MAX_FLOORS-1:0] calls,
                                      input logic [MAX_FW-1:0]     pos);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (calls[i] && (i < int'(pos))) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/elevator_cycle_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
// Load wins over run; the count parks at zero rather than wrapping.
module elevator_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         run,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (run && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/elevator_dispatcher.sv
// SCAN dispatcher: latches floor calls, pulses up/down to the car, waits for the
// floor to change, and holds the door at served floors. Outputs decode from state.
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter  int NUM_FLOORS   = NUM_FLOORS_DEF,
  parameter  int DOOR_CYCLES  = 8,
  parameter  int MOVE_TIMEOUT = 64,
  localparam int FW           = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic [FW-1:0]         floor,
  output logic                  up,
  output logic                  down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  fault,
  output disp_state_t           dbg_state
);

  localparam int DTW = $clog2(DOOR_CYCLES + 1);
  localparam int MTW = $clog2(MOVE_TIMEOUT);
  localparam logic [NUM_FLOORS-1:0] FLOOR0 = NUM_FLOORS'(1);

  // Handshake: none. up/down are fire-and-forget pulses; the car acknowledges
  // only by changing floor, which is watched in WAIT_MOVE under a timeout.

  disp_state_t state, next_state;
  dir_t        dir, next_dir;
  logic [FW-1:0] issue_floor;
  logic        next_fault;

  logic [MAX_FLOORS-1:0] pend_wide, req_wide;
  logic [MAX_FW-1:0]     floor_wide;
  logic        floor_legal, here, above, below;
  logic        clr_en;
  logic [NUM_FLOORS-1:0] clr;

  logic door_load, door_run, door_done;
  logic move_load, move_run, move_done;

  always_comb begin
    pend_wide  = '0;
    req_wide   = '0;
    floor_wide = '0;
    pend_wide[NUM_FLOORS-1:0] = pending;
    req_wide[NUM_FLOORS-1:0]  = req;
    floor_wide[FW-1:0]        = floor;
  end

  assign floor_legal = (floor_wide <= MAX_FW'(NUM_FLOORS - 1));
  assign here        = floor_legal && pend_wide[floor_wide];
  assign above       = call_above(pend_wide, floor_wide);
  assign below       = call_below(pend_wide, floor_wide);

  always_comb begin
    next_state = state;
    next_dir   = dir;
    next_fault = fault;
    door_load  = 1'b0;
    door_run   = 1'b0;
    move_load  = 1'b0;
    move_run   = 1'b0;
    if (!floor_legal) begin
      next_fault = 1'b1;
      next_state = IDLE;
    end else if (fault) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (here) begin
            next_state = DOOR_OPEN;
            door_load  = 1'b1;
          end else if (above && ((dir == DIR_UP) || !below)) begin
            next_state = STEP_UP;
            next_dir   = DIR_UP;
          end else if (below) begin
            next_state = STEP_DOWN;
            next_dir   = DIR_DOWN;
          end
        end
        STEP_UP, STEP_DOWN: begin
          next_state = WAIT_MOVE;
          move_load  = 1'b1;
        end
        WAIT_MOVE: begin
          if (floor != issue_floor) begin
            next_state = here ? DOOR_OPEN : IDLE;
            door_load  = here;
          end else if (move_done) begin
            next_fault = 1'b1;
            next_state = IDLE;
          end else begin
            move_run = 1'b1;
          end
        end
        DOOR_OPEN: begin
          // A press at the open floor keeps the door open instead of queueing a call.
          if (req_wide[floor_wide]) begin
            door_load = 1'b1;
          end else if (door_done) begin
            next_state = IDLE;
          end else begin
            door_run = 1'b1;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  assign clr_en = floor_legal && ((state == DOOR_OPEN) || (next_state == DOOR_OPEN));
  assign clr    = clr_en ? (FLOOR0 << floor) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dir         <= DIR_UP;
      fault       <= 1'b0;
      pending     <= '0;
      issue_floor <= '0;
    end else begin
      state   <= next_state;
      dir     <= next_dir;
      fault   <= next_fault;
      pending <= (pending | req) & ~clr;
      if ((state == STEP_UP) || (state == STEP_DOWN)) issue_floor <= floor;
    end
  end

  // Door timer holds DOOR_CYCLES-1 on the first open cycle so the door lasts DOOR_CYCLES.
  elevator_cycle_timer #(.W(DTW)) u_door_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (door_load),
    .load_value (DTW'(DOOR_CYCLES - 1)),
    .run        (door_run),
    .done       (door_done)
  );

  elevator_cycle_timer #(.W(MTW)) u_move_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (move_load),
    .load_value (MTW'(MOVE_TIMEOUT - 1)),
    .run        (move_run),
    .done       (move_done)
  );

  assign up        = (state == STEP_UP);
  assign down      = (state == STEP_DOWN);
  assign door_open = (state == DOOR_OPEN);
  assign dbg_state = state;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Bench for elevator_dispatcher: closed-loop car model, cycle-level behavioural
// reference, directed scenarios with literal expectations, and a 3-floor build.
module tb_elevator_dispatcher;
  import elevator_pkg::*;

  localparam int NF  = 4;
  localparam int DC  = 4;
  localparam int MT  = 16;
  localparam int NF3 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [NF-1:0]   req;
  logic [1:0]      floor;
  logic            up, down, door_open, fault;
  logic [NF-1:0]   pending;
  disp_state_t     dbg_state;

  logic [NF3-1:0]  req3;
  logic [1:0]      floor3;
  logic            up3, down3, door3, fault3;
  logic [NF3-1:0]  pend3;
  disp_state_t     dbg3;

  elevator_dispatcher #(.NUM_FLOORS(NF), .DOOR_CYCLES(DC), .MOVE_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset), .req(req), .floor(floor), .up(up), .down(down),
    .door_open(door_open), .pending(pending), .fault(fault), .dbg_state(dbg_state)
  );

  elevator_dispatcher #(.NUM_FLOORS(NF3), .DOOR_CYCLES(DC), .MOVE_TIMEOUT(MT)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .floor(floor3), .up(up3), .down(down3),
    .door_open(door3), .pending(pend3), .fault(fault3), .dbg_state(dbg3)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  localparam int M_IDLE = 0, M_UP = 1, M_DN = 2, M_MOVE = 3, M_DOOR = 4;
  int          m_mode = M_IDLE, m_next, m_door_left, m_waited, m_start, mf;
  bit [NF-1:0] m_pend = '0, m_clr;
  bit          m_fault = 1'b0, m_dir_up = 1'b1, m_legal, m_above, m_below;

  always @(posedge clk) begin
    mf      = int'(floor);
    m_legal = (mf < NF);
    if (reset) begin
      m_mode = M_IDLE; m_pend = '0; m_fault = 1'b0; m_dir_up = 1'b1;
      m_door_left = 0; m_waited = 0; m_start = 0;
    end else begin
      m_above = 1'b0;
      m_below = 1'b0;
      for (int i = 0; i < NF; i++) begin
        if (m_pend[i] && i > mf) m_above = 1'b1;
        if (m_pend[i] && i < mf) m_below = 1'b1;
      end
      m_next = M_IDLE;
      if (!m_legal) begin
        m_fault = 1'b1;
      end else if (!m_fault) begin
        case (m_mode)
          M_IDLE:
            if (m_pend[mf]) begin m_next = M_DOOR; m_door_left = DC; end
            else if (m_above && (m_dir_up || !m_below)) begin m_next = M_UP; m_dir_up = 1'b1; end
            else if (m_below) begin m_next = M_DN; m_dir_up = 1'b0; end
          M_UP, M_DN: begin m_next = M_MOVE; m_start = mf; m_waited = 0; end
          M_MOVE:
            if (mf != m_start) begin
              if (m_pend[mf]) begin m_next = M_DOOR; m_door_left = DC; end
            end else begin
              m_waited++;
              if (m_waited == MT) m_fault = 1'b1;
              else m_next = M_MOVE;
            end
          M_DOOR:
            if (req[mf]) begin m_door_left = DC; m_next = M_DOOR; end
            else begin
              m_door_left--;
              if (m_door_left > 0) m_next = M_DOOR;
            end
          default: ;
        endcase
      end
      m_clr = '0;
      if (m_legal && (m_mode == M_DOOR || m_next == M_DOOR)) m_clr[mf] = 1'b1;
      m_pend = (m_pend | req) & ~m_clr;
      m_mode = m_next;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (checking) begin
      check("up", up, m_mode == M_UP);
      check("down", down, m_mode == M_DN);
      check("door_open", door_open, m_mode == M_DOOR);
      check("pending", pending, m_pend);
      check("fault", fault, m_fault);
      check("pulse_gap", (up | down) && prev_pulse, 0);
      check("up_at_top", up && (floor == 2'(NF - 1)), 0);
      check("down_at_bottom", down && (floor == 2'd0), 0);
      prev_pulse = up | down;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      assert (!(up && down)) else begin
        fails++;
        $display("FAIL up_down_overlap: up=%b down=%b, required not both high", up, down);
      end
      assert (!(up3 && down3)) else begin
        fails++;
        $display("FAIL up_down_overlap3: up=%b down=%b, required not both high", up3, down3);
      end
    end
  end

  // ---------------- car model and driver tasks ----------------
  int car_cnt = 0;
  bit car_up = 1'b0, car_frozen = 1'b0;
  int n_up = 0, n_down = 0;
  bit door_prev = 1'b0;
  int door_log[$];

  task automatic tick();
    @(negedge clk);
    if (up) n_up++;
    if (down) n_down++;
    if (door_open && !door_prev) door_log.push_back(int'(floor));
    door_prev = door_open;
    if (!car_frozen) begin
      if (up || down) begin
        car_cnt = 3;
        car_up  = up;
      end else if (car_cnt > 0) begin
        car_cnt--;
        if (car_cnt == 0) floor = car_up ? floor + 2'd1 : floor - 2'd1;
      end
    end
  endtask

  task automatic restart(input logic [1:0] start_floor);
    reset = 1'b1;
    floor = start_floor;
    car_cnt = 0;
    tick();
    reset = 1'b0;
    n_up = 0;
    n_down = 0;
    door_log.delete();
  endtask

  task automatic press(input logic [NF-1:0] mask);
    req = mask;
    tick();
    req = '0;
  endtask

  task automatic settle(input string name, input int budget);
    int n;
    n = 0;
    while ((pending != '0 || door_open) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_settled"}, n < budget, 1);
  endtask

  // ---------------- directed scenarios ----------------
  int lat, len;

  initial begin
    reset = 1'b1; req = '0; floor = 2'd0; req3 = '0; floor3 = 2'd0;
    tick();
    tick();
    checking = 1'b1;
    check("rst_state", dbg_state, IDLE);
    check("rst_pending", pending, 0);
    check("rst_door", door_open, 0);
    check("rst_fault", fault, 0);
    check("rst_fault3", fault3, 0);
    reset = 1'b0;
    tick();

    // same-floor call at floor 0
    restart(2'd0);
    press(4'b0001);
    lat = 1;
    while (!door_open && lat < 20) begin tick(); lat++; end
    check("t1_latency", lat, 2);
    len = 0;
    while (door_open && len < 20) begin tick(); len++; end
    check("t1_door_len", len, DC);
    check("t1_pending", pending, 0);
    check("t1_no_moves", n_up + n_down, 0);

    // floor 0 to floor 3
    restart(2'd0);
    press(4'b1000);
    settle("t2", 200);
    check("t2_ups", n_up, 3);
    check("t2_downs", n_down, 0);
    check("t2_doors", door_log.size(), 1);
    if (door_log.size() == 1) check("t2_door_floor", door_log[0], 3);
    check("t2_floor", floor, 3);

    // SCAN from floor 2 heading up with calls at 0 and 3
    restart(2'd2);
    press(4'b1001);
    settle("t3", 300);
    check("t3_ups", n_up, 1);
    check("t3_downs", n_down, 3);
    check("t3_doors", door_log.size(), 2);
    if (door_log.size() == 2) begin
      check("t3_first_stop", door_log[0], 3);
      check("t3_second_stop", door_log[1], 0);
    end
    check("t3_floor", floor, 0);

    // re-press at the open floor reloads the door timer
    restart(2'd1);
    press(4'b0010);
    tick();
    check("t4_door_up", door_open, 1);
    tick();
    press(4'b0010);
    len = 0;
    while (door_open && len < 20) begin tick(); len++; end
    check("t4_door_after_press", len, DC);
    check("t4_pending", pending, 0);

    // stuck car: move timeout
    restart(2'd0);
    car_frozen = 1'b1;
    press(4'b0100);
    lat = 0;
    while (!up && lat < 10) begin tick(); lat++; end
    check("t5_up_seen", up, 1);
    len = 0;
    while (!fault && len < 40) begin tick(); len++; end
    check("t5_fault_delay", len, MT + 1);
    n_up = 0;
    n_down = 0;
    press(4'b0001);
    repeat (20) tick();
    check("t5_no_moves", n_up + n_down, 0);
    check("t5_pending_accum", pending, 4'b0101);
    check("t5_no_door", door_open, 0);
    check("t5_fault_sticky", fault, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_pending", pending, 0);
    check("t5_rst_fault", fault, 0);
    car_frozen = 1'b0;
    tick();

    // illegal floor on the 3-floor build
    check("t6_pre_fault", fault3, 0);
    floor3 = 2'b11;
    tick();
    check("t6_fault", fault3, 1);
    check("t6_no_up", up3, 0);
    check("t6_no_down", down3, 0);
    floor3 = 2'd0;
    req3 = 3'b010;
    tick();
    req3 = '0;
    repeat (5) begin
      tick();
      check("t6_still_no_up", up3, 0);
    end
    check("t6_pend_accum", pend3, 3'b010);
    check("t6_fault_sticky", fault3, 1);

    checking = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
